// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage controller: 32-bit load/store over a 16-bit SRAM in two half-word phases
//
// Purpose: takes the EXE byte address and store data, runs the access as a
// low half-word phase followed by a high half-word phase, and holds the
// upstream pipeline with freeze until the word is done.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_r_en, mem_w_en  load / store request (store wins when both are set)
//   alu_result          byte address from EXE
//   st_val              store data from EXE
//   freeze              stall for IF/ID/EXE/EXE-MEM registers
//   ready               one-cycle pulse when the access has finished
//   rd_data             loaded word, held until the next load completes
//   sram_addr           SRAM half-word address
//   sram_wdata          SRAM write data
//   sram_rdata          SRAM read data
//   sram_we_n           SRAM write enable, active low
//   sram_oe_n           SRAM output enable, active low

module mem_stage #(
   parameter int ADDR_BASE = 1024,
   parameter int SRAM_WAIT = 2,
   parameter int SRAM_AW   = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        alu_result,
   input  logic [31:0]        st_val,
   output logic               freeze,
   output logic               ready,
   output logic [31:0]        rd_data,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_wdata,
   input  logic [15:0]        sram_rdata,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam int          CW       = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SRAM_WAIT - 1);
   localparam logic [31:0] BASE_W   = 32'(ADDR_BASE);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               is_store;
   logic [15:0]        st_hi;
   logic               req;
   logic [SRAM_AW-1:0] lo_addr;

   assign req = mem_r_en | mem_w_en;

   // Word index doubled gives the low half-word address; the cast truncates
   // to the SRAM address width. Subtraction wraps modulo 2^32.
   assign lo_addr = SRAM_AW'(((alu_result - BASE_W) >> 2) << 1);

   // Gated by rst so the pipeline is never held while reset is asserted,
   // even if a stale request is still presented.
   assign freeze = ~rst & (((state == IDLE) & req) | (state == LO) | (state == HI));
   assign ready  = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= CNT_LOAD;
         is_store   <= 1'b0;
         st_hi      <= 16'd0;
         rd_data    <= 32'd0;
         sram_addr  <= '0;
         sram_wdata <= 16'd0;
         sram_we_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  // Everything needed later is latched here, so the EXE/MEM
                  // register contents may change freely afterwards.
                  state     <= LO;
                  cnt       <= CNT_LOAD;
                  is_store  <= mem_w_en;
                  st_hi     <= st_val[31:16];
                  sram_addr <= lo_addr;
                  if (mem_w_en) begin
                     sram_wdata <= st_val[15:0];
                     sram_we_n  <= 1'b0;
                  end else begin
                     sram_oe_n  <= 1'b0;
                  end
               end
            end
            LO: begin
               if (cnt == '0) begin
                  state        <= HI;
                  cnt          <= CNT_LOAD;
                  sram_addr[0] <= 1'b1;
                  if (is_store) begin
                     sram_wdata <= st_hi;
                  end else begin
                     rd_data[15:0] <= sram_rdata;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HI: begin
               if (cnt == '0) begin
                  state     <= DONE;
                  sram_we_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  if (!is_store) begin
                     rd_data[31:16] <= sram_rdata;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (SRAM_WAIT=2 and SRAM_WAIT=1 instances)

module tb_mem_stage;

   localparam int AW = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          r_en  [2];
   logic          w_en  [2];
   logic [31:0]   alu   [2];
   logic [31:0]   st    [2];
   logic          freeze[2];
   logic          ready [2];
   logic [31:0]   rd    [2];
   logic [AW-1:0] saddr [2];
   logic [15:0]   wdata [2];
   logic [15:0]   rdata [2];
   logic          we_n  [2];
   logic          oe_n  [2];

   mem_stage #(.ADDR_BASE(1024), .SRAM_WAIT(2), .SRAM_AW(AW)) u_dut (
      .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
      .alu_result(alu[0]), .st_val(st[0]), .freeze(freeze[0]), .ready(ready[0]),
      .rd_data(rd[0]), .sram_addr(saddr[0]), .sram_wdata(wdata[0]),
      .sram_rdata(rdata[0]), .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0])
   );

   mem_stage #(.ADDR_BASE(1024), .SRAM_WAIT(1), .SRAM_AW(AW)) u_dut_w1 (
      .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
      .alu_result(alu[1]), .st_val(st[1]), .freeze(freeze[1]), .ready(ready[1]),
      .rd_data(rd[1]), .sram_addr(saddr[1]), .sram_wdata(wdata[1]),
      .sram_rdata(rdata[1]), .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1])
   );

   // External SRAM models; reads return a marker pattern when not enabled.
   logic [15:0] mem  [2][0:(1<<AW)-1];
   logic [15:0] gold [2][0:(1<<AW)-1];
   logic [31:0] last_rd [2];

   always @(posedge clk) begin
      if (!we_n[0]) mem[0][saddr[0]] <= wdata[0];
      if (!we_n[1]) mem[1][saddr[1]] <= wdata[1];
   end
   assign rdata[0] = oe_n[0] ? 16'hA5A5 : mem[0][saddr[0]];
   assign rdata[1] = oe_n[1] ? 16'hA5A5 : mem[1][saddr[1]];

   int checks   = 0;
   int failures = 0;

   function automatic logic [AW-1:0] half_addr(input logic [31:0] a, input bit hi);
      logic [31:0] w;
      logic [31:0] r;
      w = (a - 32'd1024) / 4;
      r = w * 2 + (hi ? 32'd1 : 32'd0);
      return r[AW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on instance sel, starting now (just after a rising edge) with
   // the request first seen in IDLE. Checks every cycle up to and including ready.
   task automatic do_access(input int sel, input bit r, input bit w,
                            input logic [31:0] a, input logic [31:0] d);
      int            wt;
      int            last;
      logic [AW-1:0] alo;
      logic [AW-1:0] ahi;
      logic [31:0]   exp_rd;
      wt   = (sel == 0) ? 2 : 1;
      last = 2 * wt + 1;
      alo  = half_addr(a, 1'b0);
      ahi  = half_addr(a, 1'b1);
      if (w) begin
         gold[sel][alo] = d[15:0];
         gold[sel][ahi] = d[31:16];
         exp_rd = last_rd[sel];
      end else begin
         exp_rd = {gold[sel][ahi], gold[sel][alo]};
      end
      r_en[sel] = r; w_en[sel] = w; alu[sel] = a; st[sel] = d;
      for (int c = 0; c <= last; c++) begin
         logic in_lo, in_hi, e_frz, e_rdy, e_we, e_oe;
         logic [AW-1:0] e_addr;
         logic [15:0]   e_wd;
         @(negedge clk);
         in_lo  = (c >= 1) && (c <= wt);
         in_hi  = (c > wt) && (c <= 2 * wt);
         e_frz  = (c < last);
         e_rdy  = (c == last);
         e_we   = !(w && (in_lo || in_hi));
         e_oe   = !(!w && (in_lo || in_hi));
         e_addr = in_lo ? alo : ahi;
         e_wd   = in_lo ? d[15:0] : d[31:16];
         checks++;
         if (freeze[sel] !== e_frz) begin
            failures++;
            $display("FAIL freeze inst=%0d cyc=%0d got=%b exp=%b", sel, c, freeze[sel], e_frz);
         end
         checks++;
         if (ready[sel] !== e_rdy) begin
            failures++;
            $display("FAIL ready inst=%0d cyc=%0d got=%b exp=%b", sel, c, ready[sel], e_rdy);
         end
         checks++;
         if (we_n[sel] !== e_we) begin
            failures++;
            $display("FAIL we_n inst=%0d cyc=%0d got=%b exp=%b", sel, c, we_n[sel], e_we);
         end
         checks++;
         if (oe_n[sel] !== e_oe) begin
            failures++;
            $display("FAIL oe_n inst=%0d cyc=%0d got=%b exp=%b", sel, c, oe_n[sel], e_oe);
         end
         if (in_lo || in_hi) begin
            checks++;
            if (saddr[sel] !== e_addr) begin
               failures++;
               $display("FAIL sram_addr inst=%0d cyc=%0d got=%h exp=%h", sel, c, saddr[sel], e_addr);
            end
            if (w) begin
               checks++;
               if (wdata[sel] !== e_wd) begin
                  failures++;
                  $display("FAIL sram_wdata inst=%0d cyc=%0d got=%h exp=%h", sel, c, wdata[sel], e_wd);
               end
            end
         end
         if (w || c == last) begin
            checks++;
            if (rd[sel] !== exp_rd) begin
               failures++;
               $display("FAIL rd_data inst=%0d cyc=%0d got=%h exp=%h", sel, c, rd[sel], exp_rd);
            end
         end
         tick();
         // Address/data are latched on entry; scrambling them must not matter.
         alu[sel] = $urandom;
         st[sel]  = $urandom;
      end
      if (!w) last_rd[sel] = exp_rd;
      r_en[sel] = 1'b0;
      w_en[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         r_en[i] = 1'b0; w_en[i] = 1'b1; alu[i] = 32'd1032; st[i] = 32'h0;
      end
      tick();
      tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (freeze[i] !== 1'b0) begin failures++; $display("FAIL reset_freeze inst=%0d got=%b exp=0", i, freeze[i]); end
         checks++;
         if (ready[i] !== 1'b0) begin failures++; $display("FAIL reset_ready inst=%0d got=%b exp=0", i, ready[i]); end
         checks++;
         if (we_n[i] !== 1'b1) begin failures++; $display("FAIL reset_we_n inst=%0d got=%b exp=1", i, we_n[i]); end
         checks++;
         if (oe_n[i] !== 1'b1) begin failures++; $display("FAIL reset_oe_n inst=%0d got=%b exp=1", i, oe_n[i]); end
         checks++;
         if (rd[i] !== 32'd0) begin failures++; $display("FAIL reset_rd_data inst=%0d got=%h exp=0", i, rd[i]); end
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w_en[i] = 1'b0;
         last_rd[i] = 32'd0;
      end
      tick();
   endtask

   task automatic test_store_load_fixed();
      do_access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
      tick();
      do_access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
      tick();
   endtask

   task automatic test_both_enables();
      do_access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
      do_access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      tick();
   endtask

   task automatic test_addr_wrap();
      logic [31:0] d;
      d = $urandom;
      do_access(0, 1'b0, 1'b1, 32'h0000_0013, d);
      do_access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 16; k++) begin
         logic [31:0] d;
         d = $urandom;
         do_access(0, 1'($urandom_range(0, 1)), 1'b1, 32'd1024 + 32'(4 * k), d);
      end
      for (int n = 0; n < 40; n++) begin
         int op, gap;
         logic [31:0] a, d;
         op  = $urandom_range(0, 2);
         gap = $urandom_range(0, 2);
         a   = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         d   = $urandom;
         do_access(0, (op != 1), (op != 0), a, d);
         repeat (gap) tick();
      end
   endtask

   task automatic test_back_to_back();
      do_access(1, 1'b0, 1'b1, 32'd1024, $urandom);
      do_access(1, 1'b0, 1'b1, 32'd1028, $urandom);
      do_access(1, 1'b1, 1'b0, 32'd1024, 32'h0);
      do_access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
      tick();
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] ahi;
      ahi = half_addr(32'd1824, 1'b1);
      r_en[0] = 1'b0; w_en[0] = 1'b1; alu[0] = 32'd1824; st[0] = $urandom;
      tick(); tick(); tick();
      @(negedge clk);
      checks++;
      if (saddr[0] !== ahi || we_n[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_hi_phase got=%h/%b exp=%h/0", saddr[0], we_n[0], ahi);
      end
      rst = 1'b1;
      w_en[0] = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) last_rd[i] = 32'd0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (ready[0] !== 1'b0 || freeze[0] !== 1'b0 || we_n[0] !== 1'b1 || oe_n[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort cyc=%0d got rdy=%b frz=%b we_n=%b oe_n=%b exp 0/0/1/1",
                     c, ready[0], freeze[0], we_n[0], oe_n[0]);
         end
         if (c == 0) begin
            checks++;
            if (rd[0] !== 32'd0) begin failures++; $display("FAIL abort_rd_data got=%h exp=0", rd[0]); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_store_load_fixed();
      test_both_enables();
      test_addr_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
